// File: rtl/hidden_cpu_fetch.sv
// Instruction fetch/buffer stage for the HiddenCPU: serially loaded program memory
// streamed to the execute core one instruction per cycle under valid/ready.
module hidden_cpu_fetch #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [5:0]    instr_in,
    input  logic          run_en,
    input  logic          jump_en,
    input  logic [AW-1:0] jump_target,
    input  logic          ready,
    output logic          instr_valid,
    output logic [1:0]    opcode,
    output logic [1:0]    reg0_addr,
    output logic [1:0]    reg1_addr,
    output logic [AW-1:0] pc,
    output logic [AW:0]   prog_len,
    output logic          full,
    output logic [1:0]    state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [AW:0]   DEPTH_LEN = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PC_ONE    = AW'(1);

    logic [5:0]    mem [DEPTH];
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] fetch_pc;
    logic          at_last;
    logic          jump_ok;

    assign full     = (prog_len == DEPTH_LEN);
    assign pc_inc   = pc + PC_ONE;
    assign at_last  = ({1'b0, pc} == (prog_len - LEN_ONE));
    assign fetch_pc = at_last ? '0 : pc_inc;
    assign jump_ok  = ({1'b0, jump_target} < prog_len);

    // A load started from IDLE always restarts at slot 0, replacing the old program.
    assign wr_addr = (state == IDLE) ? '0 : prog_len[AW-1:0];
    assign wr_en   = !rst && load_en && ((state == IDLE) || ((state == LOAD) && !full));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= instr_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            prog_len    <= '0;
            pc          <= '0;
            instr_valid <= 1'b0;
            opcode      <= '0;
            reg0_addr   <= '0;
            reg1_addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_en) begin
                        state    <= LOAD;
                        prog_len <= LEN_ONE;
                    end else if (run_en && (prog_len != '0)) begin
                        state       <= RUN;
                        pc          <= '0;
                        instr_valid <= 1'b0;
                    end
                end
                LOAD: begin
                    if (!load_en) begin
                        state <= IDLE;
                    end else if (!full) begin
                        prog_len <= prog_len + LEN_ONE;
                    end
                end
                RUN: begin
                    // Priority: run drop, then jump (beats an accept), then accept, then refill.
                    if (!run_en) begin
                        state       <= IDLE;
                        instr_valid <= 1'b0;
                    end else if (jump_en && jump_ok) begin
                        pc          <= jump_target;
                        instr_valid <= 1'b0;
                    end else if (instr_valid && ready) begin
                        if (at_last && !WRAP) begin
                            state       <= DONE;
                            instr_valid <= 1'b0;
                        end else begin
                            pc                                <= fetch_pc;
                            {opcode, reg0_addr, reg1_addr}    <= mem[fetch_pc];
                            instr_valid                       <= 1'b1;
                        end
                    end else if (!instr_valid) begin
                        {opcode, reg0_addr, reg1_addr} <= mem[pc];
                        instr_valid                    <= 1'b1;
                    end
                end
                default: begin
                    if (!run_en) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hidden_cpu_fetch.sv
// Directed self-checking bench for hidden_cpu_fetch; instance a uses WRAP=1, instance b WRAP=0.
module tb_hidden_cpu_fetch;

    logic       clk = 1'b0;
    logic       rst, load_en, run_en, jump_en, ready;
    logic [5:0] instr_in;
    logic [3:0] jump_target;

    logic       valid_a, valid_b, full_a, full_b;
    logic [1:0] opcode_a, reg0_a, reg1_a, state_a;
    logic [1:0] opcode_b, reg0_b, reg1_b, state_b;
    logic [3:0] pc_a, pc_b;
    logic [4:0] len_a, len_b;

    int compared   = 0;
    int mismatched = 0;

    logic [5:0] prog3 [3];
    logic [5:0] word;

    always #5 clk = ~clk;

    hidden_cpu_fetch #(.DEPTH(16), .AW(4), .WRAP(1'b1)) dut_a (
        .clk(clk), .rst(rst), .load_en(load_en), .instr_in(instr_in), .run_en(run_en),
        .jump_en(jump_en), .jump_target(jump_target), .ready(ready),
        .instr_valid(valid_a), .opcode(opcode_a), .reg0_addr(reg0_a), .reg1_addr(reg1_a),
        .pc(pc_a), .prog_len(len_a), .full(full_a), .state(state_a)
    );

    hidden_cpu_fetch #(.DEPTH(16), .AW(4), .WRAP(1'b0)) dut_b (
        .clk(clk), .rst(rst), .load_en(load_en), .instr_in(instr_in), .run_en(run_en),
        .jump_en(jump_en), .jump_target(jump_target), .ready(ready),
        .instr_valid(valid_b), .opcode(opcode_b), .reg0_addr(reg0_b), .reg1_addr(reg1_b),
        .pc(pc_b), .prog_len(len_b), .full(full_b), .state(state_b)
    );

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic r, input logic ld, input logic [5:0] ins,
                                 input logic rn, input logic j, input logic [3:0] tgt,
                                 input logic rdy);
        rst         = r;
        load_en     = ld;
        instr_in    = ins;
        run_en      = rn;
        jump_en     = j;
        jump_target = tgt;
        ready       = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        prog3[0] = 6'h1B;
        prog3[1] = 6'h24;
        prog3[2] = 6'h3F;

        // Reset state
        applyStimulus(1, 0, 6'h00, 0, 0, 4'd0, 0);
        checkOutput("rst_state_a", state_a, 0);
        checkOutput("rst_valid_a", valid_a, 0);
        checkOutput("rst_pc_a", pc_a, 0);
        checkOutput("rst_len_a", len_a, 0);
        checkOutput("rst_full_a", full_a, 0);
        checkOutput("rst_word_a", {opcode_a, reg0_a, reg1_a}, 0);
        checkOutput("rst_state_b", state_b, 0);

        // Load three words
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, prog3[i], 0, 0, 4'd0, 0);
            checkOutput("load3_state", state_a, 1);
            checkOutput("load3_len", len_a, i + 1);
        end
        applyStimulus(0, 0, 6'h00, 0, 0, 4'd0, 0);
        checkOutput("load3_idle", state_a, 0);
        checkOutput("load3_len_final", len_a, 3);

        // Run with ready held high: one cycle of entry latency, then a continuous stream
        applyStimulus(0, 0, 6'h00, 1, 0, 4'd0, 1);
        checkOutput("run_entry_state", state_a, 2);
        checkOutput("run_entry_valid", valid_a, 0);
        applyStimulus(0, 0, 6'h00, 1, 0, 4'd0, 1);
        checkOutput("first_opcode", opcode_a, 1);
        checkOutput("first_reg0", reg0_a, 2);
        checkOutput("first_reg1", reg1_a, 3);
        checkOutput("first_pc", pc_a, 0);
        for (int i = 1; i < 5; i++) begin
            applyStimulus(0, 0, 6'h00, 1, 0, 4'd0, 1);
            checkOutput("stream_valid", valid_a, 1);
            checkOutput("stream_pc", pc_a, i % 3);
            checkOutput("stream_word", {opcode_a, reg0_a, reg1_a}, prog3[i % 3]);
        end

        // Drop run, restart, then exercise back-pressure
        applyStimulus(0, 0, 6'h00, 0, 0, 4'd0, 1);
        checkOutput("drop_state", state_a, 0);
        checkOutput("drop_valid", valid_a, 0);
        applyStimulus(0, 0, 6'h00, 1, 0, 4'd0, 0);
        applyStimulus(0, 0, 6'h00, 1, 0, 4'd0, 0);
        checkOutput("restart_pc", pc_a, 0);
        checkOutput("restart_word", {opcode_a, reg0_a, reg1_a}, 6'h1B);
        applyStimulus(0, 0, 6'h00, 1, 0, 4'd0, 1);
        checkOutput("bp_accept_pc", pc_a, 1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 6'h00, 1, 0, 4'd0, 0);
            checkOutput("bp_hold_pc", pc_a, 1);
            checkOutput("bp_hold_word", {opcode_a, reg0_a, reg1_a}, 6'h24);
            checkOutput("bp_hold_valid", valid_a, 1);
        end
        applyStimulus(0, 0, 6'h00, 1, 0, 4'd0, 1);
        checkOutput("bp_next_pc", pc_a, 2);
        checkOutput("bp_next_word", {opcode_a, reg0_a, reg1_a}, 6'h3F);

        // Out-of-range jump ignored; in-range jump beats a simultaneous accept
        applyStimulus(0, 0, 6'h00, 1, 1, 4'd5, 0);
        checkOutput("jump_oor_pc", pc_a, 2);
        checkOutput("jump_oor_valid", valid_a, 1);
        applyStimulus(0, 0, 6'h00, 1, 1, 4'd1, 1);
        checkOutput("jump_acc_bubble", valid_a, 0);
        checkOutput("jump_acc_pc", pc_a, 1);
        applyStimulus(0, 0, 6'h00, 1, 0, 4'd0, 1);
        checkOutput("jump_acc_valid", valid_a, 1);
        checkOutput("jump_acc_word", {opcode_a, reg0_a, reg1_a}, 6'h24);

        // Two-word program: WRAP=0 stops in DONE, WRAP=1 wraps without a bubble
        applyStimulus(0, 0, 6'h00, 0, 0, 4'd0, 0);
        applyStimulus(0, 1, 6'h05, 0, 0, 4'd0, 0);
        applyStimulus(0, 1, 6'h2A, 0, 0, 4'd0, 0);
        applyStimulus(0, 0, 6'h00, 0, 0, 4'd0, 0);
        checkOutput("load2_len_b", len_b, 2);
        applyStimulus(0, 0, 6'h00, 1, 0, 4'd0, 1);
        applyStimulus(0, 0, 6'h00, 1, 0, 4'd0, 1);
        checkOutput("w0_first_word_b", {opcode_b, reg0_b, reg1_b}, 6'h05);
        applyStimulus(0, 0, 6'h00, 1, 0, 4'd0, 1);
        checkOutput("w0_second_word_b", {opcode_b, reg0_b, reg1_b}, 6'h2A);
        applyStimulus(0, 0, 6'h00, 1, 0, 4'd0, 1);
        checkOutput("w0_done_state", state_b, 3);
        checkOutput("w0_done_valid", valid_b, 0);
        checkOutput("w0_done_pc", pc_b, 1);
        checkOutput("w1_wrap_pc", pc_a, 0);
        checkOutput("w1_wrap_valid", valid_a, 1);
        checkOutput("w1_wrap_word", {opcode_a, reg0_a, reg1_a}, 6'h05);
        applyStimulus(0, 0, 6'h00, 1, 0, 4'd0, 1);
        checkOutput("w0_done_hold", state_b, 3);
        applyStimulus(0, 0, 6'h00, 0, 0, 4'd0, 1);
        checkOutput("w0_exit_state", state_b, 0);

        // Overfill: DEPTH+2 writes, the last two are dropped
        for (int i = 0; i < 18; i++) begin
            word = 6'((i * 5 + 3) & 63);
            applyStimulus(0, 1, word, 0, 0, 4'd0, 0);
            checkOutput("fill_len", len_a, (i + 1 > 16) ? 16 : i + 1);
        end
        checkOutput("fill_full", full_a, 1);
        applyStimulus(0, 0, 6'h00, 0, 0, 4'd0, 0);
        applyStimulus(0, 0, 6'h00, 1, 0, 4'd0, 0);
        applyStimulus(0, 0, 6'h00, 1, 0, 4'd0, 0);
        checkOutput("fill_slot0", {opcode_a, reg0_a, reg1_a}, 6'd3);
        applyStimulus(0, 0, 6'h00, 1, 1, 4'd5, 0);
        checkOutput("jump5_bubble", valid_a, 0);
        applyStimulus(0, 0, 6'h00, 1, 0, 4'd0, 0);
        checkOutput("jump5_pc", pc_a, 5);
        checkOutput("jump5_valid", valid_a, 1);
        checkOutput("jump5_word", {opcode_a, reg0_a, reg1_a}, 6'd28);
        applyStimulus(0, 0, 6'h00, 1, 1, 4'd15, 0);
        applyStimulus(0, 0, 6'h00, 1, 0, 4'd0, 0);
        checkOutput("slot15_pc", pc_a, 15);
        checkOutput("slot15_word", {opcode_a, reg0_a, reg1_a}, 6'd14);
        applyStimulus(0, 0, 6'h00, 1, 0, 4'd0, 1);
        checkOutput("full_wrap_pc", pc_a, 0);
        checkOutput("full_wrap_word", {opcode_a, reg0_a, reg1_a}, 6'd3);
        checkOutput("full_done_b", state_b, 3);
        checkOutput("full_done_pc_b", pc_b, 15);

        // Reset in the middle of RUN with a valid instruction pending
        checkOutput("pre_rst_valid", valid_a, 1);
        applyStimulus(1, 0, 6'h00, 1, 0, 4'd0, 1);
        checkOutput("midrst_state", state_a, 0);
        checkOutput("midrst_valid", valid_a, 0);
        checkOutput("midrst_pc", pc_a, 0);
        checkOutput("midrst_len", len_a, 0);
        checkOutput("midrst_full", full_a, 0);
        checkOutput("midrst_word", {opcode_a, reg0_a, reg1_a}, 0);
        applyStimulus(0, 0, 6'h00, 1, 1, 4'd2, 1);
        checkOutput("norun_empty_state", state_a, 0);
        checkOutput("jump_idle_pc", pc_a, 0);
        applyStimulus(0, 0, 6'h00, 1, 0, 4'd0, 1);
        checkOutput("norun_empty_valid", valid_a, 0);

        // load_en beats run_en in IDLE
        applyStimulus(0, 1, 6'h33, 1, 0, 4'd0, 1);
        checkOutput("ldrun_state", state_a, 1);
        checkOutput("ldrun_valid", valid_a, 0);
        checkOutput("ldrun_len", len_a, 1);
        applyStimulus(0, 0, 6'h00, 0, 0, 4'd0, 1);
        checkOutput("ldrun_idle", state_a, 0);
        checkOutput("ldrun_idle_valid", valid_a, 0);
        applyStimulus(0, 0, 6'h00, 1, 0, 4'd0, 1);
        applyStimulus(0, 0, 6'h00, 1, 0, 4'd0, 1);
        checkOutput("ldrun_slot0", {opcode_a, reg0_a, reg1_a}, 6'h33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
